// File: rtl/fifo_serial_pkg.sv
// Shared types and constants for the FIFO-to-serial transmitter.
package fifo_serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        WAIT   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } tx_state_e;

    localparam logic TX_IDLE  = 1'b1;
    localparam logic TX_START = 1'b0;

    // Clock cycles from the falling start edge to the end of the stop bit.
    function automatic int unsigned frame_cycles(input int unsigned data_w,
                                                 input int unsigned clks_per_bit,
                                                 input bit          parity_en);
        return (2 + data_w + (parity_en ? 1 : 0)) * clks_per_bit;
    endfunction

endpackage

// File: rtl/fifo_serial_tx_baud_tick_gen.sv
// Bit-period timer: tick marks the last clock of each serial bit while run is high.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick,
    output logic tick_next
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = run && (cnt_q == LAST);

    always_comb begin
        cnt_d = '0;
        if (run && !tick) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // tick_next lets the owner register a flag that lines up with the next tick.
    assign tick_next = (cnt_d == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops words from sync_fifo and sends each as a start/data/[parity]/stop frame on tx.
module fifo_serial_tx
    import fifo_serial_pkg::*;
#(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter int LSB_FIRST    = 1,
    parameter int PARITY_EN    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              word_done
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_W - 1);

    tx_state_e         state_q;
    logic [DATA_W-1:0] shift_q;
    logic              parity_q;
    logic [IDX_W-1:0]  bit_q;
    logic              rd_en_q;
    logic              tx_q;
    logic              busy_q;
    logic              done_q;

    logic run;
    logic tick;
    logic tick_next;
    logic can_pop;

    assign run     = (state_q == START) || (state_q == DATA) ||
                     (state_q == PARITY) || (state_q == STOP);
    assign can_pop = enable && !fifo_empty;

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .tick      (tick),
        .tick_next (tick_next)
    );

    function automatic logic next_bit(input logic [DATA_W-1:0] s);
        return (LSB_FIRST != 0) ? s[0] : s[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] s);
        return (LSB_FIRST != 0) ? (s >> 1) : (s << 1);
    endfunction

    // tx is registered and loaded with the value of the bit being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            parity_q <= 1'b0;
            bit_q    <= '0;
            rd_en_q  <= 1'b0;
            tx_q     <= TX_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (can_pop) begin
                        state_q <= POP;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                POP: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    shift_q  <= fifo_rdata;
                    parity_q <= ^fifo_rdata;
                    tx_q     <= TX_START;
                    state_q  <= START;
                end
                START: begin
                    if (tick) begin
                        tx_q    <= next_bit(shift_q);
                        shift_q <= shift_out(shift_q);
                        bit_q   <= '0;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_q == LAST_BIT) begin
                            bit_q <= '0;
                            if (PARITY_EN != 0) begin
                                tx_q    <= parity_q;
                                state_q <= PARITY;
                            end else begin
                                tx_q    <= TX_IDLE;
                                done_q  <= tick_next;
                                state_q <= STOP;
                            end
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            tx_q    <= next_bit(shift_q);
                            shift_q <= shift_out(shift_q);
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        tx_q    <= TX_IDLE;
                        done_q  <= tick_next;
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    // Chaining straight into POP keeps busy high across a burst.
                    if (tick) begin
                        if (can_pop) begin
                            state_q <= POP;
                            rd_en_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        done_q <= tick_next;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= TX_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign word_done  = done_q;

endmodule

// File: doc/fifo_serial_tx.md
Name: fifo_serial_tx

Overview:
Read-side consumer for sync_fifo. It pops one DATA_W-bit word at a time through the FIFO's rd_en/data_out/empty interface and sends it as an asynchronous serial frame on a single tx line. Each frame is a start bit, the data bits, an optional even-parity bit and a stop bit. The block sits directly downstream of the FIFO and is the team's first off-chip serial link for FIFO contents.

Parameters:
DATA_W, 4, word width; matches the FIFO data width.
CLKS_PER_BIT, 4, clk cycles per serial bit; legal range 1..65535.
LSB_FIRST, 1, 1 = data bit 0 is sent first; 0 = MSB is sent first.
PARITY_EN, 0, 1 = insert an even-parity bit between the last data bit and the stop bit.

Ports:
clk  input  1  single system clock; all logic is on the rising edge.
reset  input  1  asynchronous, active-low reset (0 = in reset).
enable  input  1  permits new pops; does not abort a frame in flight.
fifo_empty  input  1  FIFO empty flag.
fifo_rdata  input  DATA_W  FIFO data_out; valid on the cycle after the fifo_rd_en cycle.
fifo_rd_en  output  1  registered one-cycle pop strobe to the FIFO.
tx  output  1  serial line; idle level is 1.
busy  output  1  1 whenever the state is not IDLE.
word_done  output  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset (reset=0, async): state=IDLE, tx=1, fifo_rd_en=0, busy=0, word_done=0, counters=0, shift register=0. All of these take effect immediately, without waiting for a clock.
- Every output is registered.
- States: IDLE, POP, WAIT, START, DATA, PARITY, STOP.
- IDLE: at an edge where enable=1 and fifo_empty=0, go to POP; fifo_rd_en=1 for that one cycle only. fifo_rd_en is never asserted from a decision made with fifo_empty=1.
- POP -> WAIT unconditionally; fifo_rd_en returns to 0.
- WAIT: at the end of this cycle, capture fifo_rdata into the shift register and go to START; tx=0 from that edge.
- Latency: tx falls at the 2nd rising edge after the IDLE decision edge.
- START, DATA, PARITY and STOP each hold tx for exactly CLKS_PER_BIT cycles, timed by the bit-tick counter.
- DATA sends DATA_W bits; order is set by LSB_FIRST. The bit index counts 0..DATA_W-1, then the state moves on.
- PARITY is entered only when PARITY_EN=1; tx = XOR of all captured data bits (even parity).
- STOP: tx=1. word_done=1 on the final cycle of STOP.
- STOP exit: if enable=1 and fifo_empty=0 go to POP, otherwise go to IDLE. In the back-to-back case, tx stays 1 through POP and WAIT, giving CLKS_PER_BIT + 2 high cycles between frames.
- enable deasserted mid-frame: the current frame completes unchanged, then the block returns to IDLE.
- fifo_rdata is sampled only in WAIT; later changes to it do not affect the frame.
- Reset mid-frame: tx returns to 1 immediately and the partial frame is dropped. The word was already popped, so it is lost. This is the defined behaviour.
- Frame length: (1 + DATA_W + PARITY_EN + 1) * CLKS_PER_BIT cycles.
- Bit-tick counter width: clog2(CLKS_PER_BIT), minimum 1. It wraps to 0 on every bit boundary.

Decomposition:
- Shared package fifo_serial_pkg holds:
  - the state encoding (3-bit, values IDLE=0..STOP=6),
  - the TX_IDLE=1 and TX_START=0 constants,
  - the frame-length function.
- One sub-module: baud_tick_gen.
  - Parameter: CLKS_PER_BIT. Ports: clk, reset, run, tick.
  - tick is high on the last cycle of each bit. The counter clears while run=0.

Test Plan:
1. Reset check: hold reset=0 for 20 cycles, then release. -> tx=1, busy=0, fifo_rd_en=0, word_done=0 throughout, and no pop without enable.
2. Single word, CLKS_PER_BIT=4, LSB_FIRST=1: FIFO holds 4'hA, enable=1. -> exactly one fifo_rd_en pulse; tx shows 0,0,1,0,1,1, each held 4 cycles; one word_done pulse on cycle 24 of the frame. With PARITY_EN=1 and word 4'h7, the parity bit is 1.
3. Back-to-back: FIFO is loaded with 0,1,2,3. -> four frames in order, 6 tx-high cycles between frames, four rd_en pulses, then IDLE with busy=0 once empty=1.
4. Empty hold: enable=1, fifo_empty=1 for 100 cycles. -> fifo_rd_en never 1, tx=1, busy=0.
5. Enable drop: FIFO holds 5..10; deassert enable during the DATA bits of word 5. -> word 5 completes, then no further pops and the FIFO still holds 6..10.
6. Mid-frame reset: assert reset=0 during data bit 2 of word 12. -> tx=1 and busy=0 in the same cycle. After release, the next frame carries word 13.
